// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, drives a 1-cycle-latency instruction memory and loads IF/ID,
// with a one-entry skid buffer for stalls. `define FETCH_PERF_CNT_EN to add stall/flush counters.
module instruction_fetch_unit #(
    parameter int unsigned              XLEN        = 32,
    parameter int unsigned              INSTR_WIDTH = 32,
    parameter logic [XLEN-1:0]          RESET_PC    = 32'h0000_0000,
    parameter logic [INSTR_WIDTH-1:0]   NOP_INSTR   = 32'h0000_0013
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    stall_i,
    input  logic                    flush_i,
    input  logic [XLEN-1:0]         branch_target_i,
    output logic [XLEN-1:0]         imem_addr_o,
    output logic                    imem_rd_en_o,
    input  logic [INSTR_WIDTH-1:0]  imem_rdata_i,
    output logic [XLEN-1:0]         pc_ID_o,
    output logic [XLEN-1:0]         pc_plus4_ID_o,
    output logic [INSTR_WIDTH-1:0]  instr_ID_o,
    output logic                    valid_ID_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]             stall_cnt_o,
    output logic [31:0]             flush_cnt_o
`endif
);

    logic [XLEN-1:0]        r_pc_issue;
    logic                   r_rsp_valid;
    logic [XLEN-1:0]        r_rsp_pc;
    logic                   r_hold_valid;
    logic [INSTR_WIDTH-1:0] r_hold_instr;
    logic [XLEN-1:0]        r_hold_pc;
    logic [XLEN-1:0]        r_pc_id;
    logic [INSTR_WIDTH-1:0] r_instr_id;
    logic                   r_valid_id;

    logic [XLEN-1:0]        w_addr;
    logic                   w_issue;
    logic                   w_cand_valid;
    logic [INSTR_WIDTH-1:0] w_cand_instr;
    logic [XLEN-1:0]        w_cand_pc;

    // A redirect is word-aligned: the low two target bits are dropped.
    assign w_addr       = flush_i ? {branch_target_i[XLEN-1:2], 2'b00} : r_pc_issue;
    assign w_issue      = !rst_i && (flush_i || !stall_i);
    assign imem_addr_o  = w_addr;
    assign imem_rd_en_o = w_issue;

    // The skid buffer outranks the memory port: it holds the older instruction.
    always_comb begin
        w_cand_valid = 1'b0;
        w_cand_instr = NOP_INSTR;
        w_cand_pc    = r_pc_id;
        if (r_hold_valid) begin
            w_cand_valid = 1'b1;
            w_cand_instr = r_hold_instr;
            w_cand_pc    = r_hold_pc;
        end else if (r_rsp_valid) begin
            w_cand_valid = 1'b1;
            w_cand_instr = imem_rdata_i;
            w_cand_pc    = r_rsp_pc;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pc_issue   <= RESET_PC;
            r_rsp_valid  <= 1'b0;
            r_rsp_pc     <= '0;
            r_hold_valid <= 1'b0;
            r_hold_instr <= NOP_INSTR;
            r_hold_pc    <= '0;
            r_pc_id      <= '0;
            r_instr_id   <= NOP_INSTR;
            r_valid_id   <= 1'b0;
        end else begin
            if (w_issue) begin
                r_rsp_valid <= 1'b1;
                r_rsp_pc    <= w_addr;
                r_pc_issue  <= w_addr + XLEN'(4);
            end else begin
                r_rsp_valid <= 1'b0;
            end

            if (flush_i) begin
                r_valid_id   <= 1'b0;
                r_instr_id   <= NOP_INSTR;
                r_hold_valid <= 1'b0;
            end else if (stall_i) begin
                if (r_rsp_valid && !r_hold_valid) begin
                    r_hold_valid <= 1'b1;
                    r_hold_instr <= imem_rdata_i;
                    r_hold_pc    <= r_rsp_pc;
                end
            end else begin
                r_hold_valid <= 1'b0;
                r_valid_id   <= w_cand_valid;
                r_instr_id   <= w_cand_instr;
                r_pc_id      <= w_cand_pc;
            end
        end
    end

    assign pc_ID_o       = r_pc_id;
    assign pc_plus4_ID_o = r_pc_id + XLEN'(4);
    assign instr_ID_o    = r_instr_id;
    assign valid_ID_o    = r_valid_id;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // Saturating event counters; a flush cycle is never counted as a stall.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (stall_i && !flush_i && (r_stall_cnt != 32'hFFFF_FFFF))
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (flush_i && (r_flush_cnt != 32'hFFFF_FFFF))
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit; memory model returns word = address, one cycle after the read.
module tb_instruction_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] branch_target_i;
    logic [31:0] imem_addr_o;
    logic        imem_rd_en_o;
    logic [31:0] imem_rdata_i;
    logic [31:0] pc_ID_o;
    logic [31:0] pc_plus4_ID_o;
    logic [31:0] instr_ID_o;
    logic        valid_ID_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;
`endif

    localparam logic [31:0] NOP = 32'h0000_0013;

    int n_vec = 0;
    int n_err = 0;

    instruction_fetch_unit dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .branch_target_i (branch_target_i),
        .imem_addr_o     (imem_addr_o),
        .imem_rd_en_o    (imem_rd_en_o),
        .imem_rdata_i    (imem_rdata_i),
        .pc_ID_o         (pc_ID_o),
        .pc_plus4_ID_o   (pc_plus4_ID_o),
        .instr_ID_o      (instr_ID_o),
        .valid_ID_o      (valid_ID_o)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cnt_o     (stall_cnt_o),
        .flush_cnt_o     (flush_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Synchronous memory: each word holds its own address.
    initial imem_rdata_i = 32'hDEAD_BEEF;
    always @(posedge clk_i) if (imem_rd_en_o) imem_rdata_i <= imem_addr_o;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_id(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] ins);
        check({tag, ".valid"}, 32'(valid_ID_o), 32'(v));
        check({tag, ".instr"}, instr_ID_o, ins);
        if (v) begin
            check({tag, ".pc"}, pc_ID_o, pc);
            check({tag, ".pc4"}, pc_plus4_ID_o, pc + 32'd4);
        end
    endtask

    task automatic check_if(input string tag, input logic en, input logic [31:0] addr);
        #1;
        check({tag, ".rd_en"}, 32'(imem_rd_en_o), 32'(en));
        if (en) check({tag, ".addr"}, imem_addr_o, addr);
    endtask

    initial begin
        rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0; branch_target_i = '0;
        #1;
        check("rst_rden", 32'(imem_rd_en_o), 32'd0);
        step();
        flush_i = 1'b1;
        check_if("rst_flush", 1'b0, 32'd0);
        flush_i = 1'b0;
        step();
        check_id("reset", 1'b0, 32'd0, NOP);
        check("reset.pc", pc_ID_o, 32'd0);
        check("reset.pc4", pc_plus4_ID_o, 32'd4);

        // Streaming from reset.
        rst_i = 1'b0;
        check_if("run0", 1'b1, 32'h0);
        step();
        check_id("run1", 1'b0, 32'h0, NOP);
        check_if("run1", 1'b1, 32'h4);
        for (int i = 0; i < 3; i++) begin
            step();
            check_id("stream", 1'b1, 32'(4 * i), 32'(4 * i));
        end

        // Two-cycle stall with pc=8 in ID and 12 in flight.
        stall_i = 1'b1;
        check_if("stall_a", 1'b0, 32'h0);
        step();
        check_id("stall1", 1'b1, 32'h8, 32'h8);
        check_if("stall_b", 1'b0, 32'h0);
        step();
        check_id("stall2", 1'b1, 32'h8, 32'h8);
        stall_i = 1'b0;
        check_if("release", 1'b1, 32'h10);
        step();
        check_id("skid", 1'b1, 32'hC, 32'hC);
        step();
        check_id("post_skid", 1'b1, 32'h10, 32'h10);

        // Run until 0x20 is in flight, then redirect.
        for (int i = 0; i < 3; i++) step();
        check_id("pre_flush", 1'b1, 32'h1C, 32'h1C);
        flush_i = 1'b1; branch_target_i = 32'h100;
        check_if("flush", 1'b1, 32'h100);
        step();
        check_id("flush_bub", 1'b0, 32'h0, NOP);
        flush_i = 1'b0;
        check_if("flush_next", 1'b1, 32'h104);
        step();
        check_id("flush_tgt", 1'b1, 32'h100, 32'h100);

        // Flush beats stall; misaligned target is word-aligned.
        flush_i = 1'b1; stall_i = 1'b1; branch_target_i = 32'h103;
        check_if("fl_st", 1'b1, 32'h100);
        step();
        check_id("fl_st_bub", 1'b0, 32'h0, NOP);
        flush_i = 1'b0; stall_i = 1'b0;
        step();
        check_id("fl_st_tgt", 1'b1, 32'h100, 32'h100);
        step();
        check_id("fl_st_next", 1'b1, 32'h104, 32'h104);

        // Reset while stalled with the skid buffer full.
        stall_i = 1'b1;
        step();
        rst_i = 1'b1;
        check_if("rst_stall", 1'b0, 32'h0);
        step();
        check_id("rst_mid", 1'b0, 32'h0, NOP);

        // Stall in the first cycle after reset: nothing issues.
        rst_i = 1'b0;
        check_if("post_rst_stall", 1'b0, 32'h0);
        step();
        check_id("post_rst_bub", 1'b0, 32'h0, NOP);
        stall_i = 1'b0;
        check_if("restart", 1'b1, 32'h0);
        step();
        check_id("restart1", 1'b0, 32'h0, NOP);
        step();
        check_id("restart2", 1'b1, 32'h0, 32'h0);

`ifdef FETCH_PERF_CNT_EN
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("cnt_rst_s", stall_cnt_o, 32'd0);
        check("cnt_rst_f", flush_cnt_o, 32'd0);
        step();
        step();
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) step();
        stall_i = 1'b0; flush_i = 1'b1; branch_target_i = 32'h40;
        step();
        flush_i = 1'b0;
        step();
        check("stall_cnt", stall_cnt_o, 32'd3);
        check("flush_cnt", flush_cnt_o, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
